// File: rtl/reg_scoreboard.sv
// Decode-stage issue controller: per-register outstanding-write counters, RAW/overflow
// stall, and a drain handshake. Optional macro WB_BYPASS_EN lets a same-cycle final retire clear hazards.
module reg_scoreboard #(
    parameter int N_REGS  = 8,
    parameter int REG_AW  = 3,
    parameter int CNT_W   = 2,
    parameter int STALL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [REG_AW-1:0]  id_rs1,
    input  logic               id_rs1_used,
    input  logic [REG_AW-1:0]  id_rs2,
    input  logic               id_rs2_used,
    input  logic [REG_AW-1:0]  id_rd,
    input  logic               id_reg_write,
    input  logic               wb_valid,
    input  logic [REG_AW-1:0]  wb_rd,
    input  logic               wb_reg_write,
    input  logic               drain_req,
    output logic               id_stall,
    output logic               id_issue,
    output logic               drain_ack,
    output logic               busy,
    output logic [STALL_W-1:0] stall_count,
    output logic               underflow_err
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [STALL_W-1:0] STALL_MAX = '1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q [N_REGS];
    logic [CNT_W-1:0]   cnt_d [N_REGS];
    logic               drain_ack_q, drain_ack_d;
    logic               busy_q, busy_d;
    logic [STALL_W-1:0] stall_count_q, stall_count_d;
    logic               underflow_err_q, underflow_err_d;

    logic               wb_retire;
    logic [N_REGS-1:0]  inc_vec;
    logic [N_REGS-1:0]  dec_vec;
    logic [N_REGS-1:0]  nonzero_q;
    logic [N_REGS-1:0]  nonzero_d;
    logic [CNT_W-1:0]   rs1_cnt, rs2_cnt, rd_cnt;
    logic               rs1_pending, rs2_pending;
    logic               hazard, overflow;
    logic               drain_clear;

    assign wb_retire = wb_valid & wb_reg_write;

    // NOTE: combinational blocks use blocking '=' and give every output a default
    // first, so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        rs1_cnt = cnt_q[id_rs1];
        rs2_cnt = cnt_q[id_rs2];
        rd_cnt  = cnt_q[id_rd];
`ifdef WB_BYPASS_EN
        // Register file is write-before-read, so the retiring value is visible this cycle.
        rs1_pending = (rs1_cnt != '0) &&
                      !((rs1_cnt == CNT_ONE) && wb_retire && (wb_rd == id_rs1));
        rs2_pending = (rs2_cnt != '0) &&
                      !((rs2_cnt == CNT_ONE) && wb_retire && (wb_rd == id_rs2));
`else
        rs1_pending = (rs1_cnt != '0);
        rs2_pending = (rs2_cnt != '0);
`endif
        hazard   = (id_rs1_used & rs1_pending) | (id_rs2_used & rs2_pending);
        overflow = id_reg_write && (rd_cnt == CNT_MAX) && !(wb_retire && (wb_rd == id_rd));
        id_stall = id_valid & (hazard | overflow | (state_q != ST_RUN));
        id_issue = id_valid & ~id_stall;
    end

    always_comb begin
        inc_vec         = '0;
        dec_vec         = '0;
        nonzero_q       = '0;
        nonzero_d       = '0;
        underflow_err_d = underflow_err_q;
        for (int r = 0; r < N_REGS; r++) begin
            inc_vec[r]   = id_issue & id_reg_write & (id_rd == REG_AW'(r));
            dec_vec[r]   = wb_retire & (wb_rd == REG_AW'(r));
            nonzero_q[r] = (cnt_q[r] != '0);
            cnt_d[r]     = cnt_q[r];
            if (inc_vec[r] && !dec_vec[r]) begin
                cnt_d[r] = cnt_q[r] + CNT_ONE;
            end else if (dec_vec[r] && !inc_vec[r]) begin
                // A retire with nothing outstanding is an error; the count stays at zero.
                if (cnt_q[r] == '0) begin
                    underflow_err_d = 1'b1;
                end else begin
                    cnt_d[r] = cnt_q[r] - CNT_ONE;
                end
            end else if (dec_vec[r] && (cnt_q[r] == '0)) begin
                underflow_err_d = 1'b1;
            end
            nonzero_d[r] = (cnt_d[r] != '0);
        end
    end

`ifdef WB_BYPASS_EN
    assign drain_clear = ~|nonzero_d;
`else
    assign drain_clear = ~|nonzero_q;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (drain_req) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!drain_req)       state_d = ST_RUN;
                else if (drain_clear) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (!drain_req) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase

        drain_ack_d   = (state_d == ST_DONE);
        busy_d        = |nonzero_q;
        stall_count_d = stall_count_q;
        if (id_stall && (stall_count_q != STALL_MAX)) begin
            stall_count_d = stall_count_q + STALL_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_RUN;
            drain_ack_q     <= 1'b0;
            busy_q          <= 1'b0;
            stall_count_q   <= '0;
            underflow_err_q <= 1'b0;
            // NOTE: the counter array is small and must restart at zero, so it is
            // reset explicitly rather than left to power-up contents like a RAM.
            for (int r = 0; r < N_REGS; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            state_q         <= state_d;
            drain_ack_q     <= drain_ack_d;
            busy_q          <= busy_d;
            stall_count_q   <= stall_count_d;
            underflow_err_q <= underflow_err_d;
            for (int r = 0; r < N_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    assign drain_ack     = drain_ack_q;
    assign busy          = busy_q;
    assign stall_count   = stall_count_q;
    assign underflow_err = underflow_err_q;

endmodule
